bitbang_cfg_rx: RTL and testbench

BITBANG_CFG_RX -- requirements
Module: bitbang_cfg_rx

---
 rtl/bitbang_cfg_pkg.sv | 18 +
 rtl/cfg_sync.sv | 30 +++
 rtl/bitbang_cfg_rx.sv | 157 +++++++++++++++
 tb/tb_bitbang_cfg_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bitbang_cfg_pkg.sv
// Shared types and constants for the bit-banged configuration receiver.
package bitbang_cfg_pkg;

  typedef logic [31:0] word_t;
  typedef logic [15:0] cnt_t;

  // Default frame-valid pattern expected in the control shift register.
  localparam word_t CTRL_WORD_DEFAULT = 32'h0000_FAB1;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Shift one serial bit into the LSB of a 32-bit register (MSB first on the wire).
  function automatic word_t shift_in(input word_t sr, input logic bit_in);
    return {sr[30:0], bit_in};
  endfunction

endpackage

// File: rtl/cfg_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
module cfg_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  // Shift the raw input toward the output end of the chain.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  // Synchronizer flops, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/bitbang_cfg_rx.sv
// Bit-banged configuration receiver.
// s_clk rising edges shift s_data into the data shift register, falling edges
// shift it into the control shift register. When the control register equals
// CTRL_WORD the data register is published on `data`, followed one cycle later
// by a one-cycle `strobe`.
// Optional build macro: BITBANG_TIMEOUT_EN adds an idle counter that clears both
// shift registers after TIMEOUT_CYCLES CLK cycles without an s_clk edge.
module bitbang_cfg_rx
  import bitbang_cfg_pkg::*;
#(
  parameter word_t       CTRL_WORD      = CTRL_WORD_DEFAULT,
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic  CLK,
  input  logic  resetn,
  input  logic  s_clk,
  input  logic  s_data,
  output word_t data,
  output logic  strobe,
  output logic  active,
  output cnt_t  word_cnt
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("bitbang_cfg_rx: SYNC_STAGES must be within 2..4");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("bitbang_cfg_rx: TIMEOUT_CYCLES must be non-zero");
  end

  logic s_clk_sync;
  logic s_data_sync;

  // Both lines use identical synchronizers so data stays aligned with its clock.
  cfg_sync #(.DEPTH(SYNC_STAGES)) u_sync_clk (
    .clk   (CLK),
    .rst_n (resetn),
    .d     (s_clk),
    .q     (s_clk_sync)
  );

  cfg_sync #(.DEPTH(SYNC_STAGES)) u_sync_data (
    .clk   (CLK),
    .rst_n (resetn),
    .d     (s_data),
    .q     (s_data_sync)
  );

  logic  s_clk_prev_q, s_clk_prev_d;
  logic  rise, fall;
  word_t data_sr_q, data_sr_d;
  word_t ctrl_sr_q, ctrl_sr_d;
  word_t ctrl_post;
  logic  accept;
  logic  accept_q, accept_d;
  word_t data_q, data_d;
  logic  strobe_q, strobe_d;
  logic  active_q, active_d;
  cnt_t  word_cnt_q, word_cnt_d;
  logic  timeout_hit;

  // Edge detection against a one-cycle-delayed copy of the synchronized clock.
  always_comb begin
    s_clk_prev_d = s_clk_sync;
    rise         = s_clk_sync & ~s_clk_prev_q;
    fall         = ~s_clk_sync & s_clk_prev_q;
  end

`ifdef BITBANG_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  // Count idle cycles since the last s_clk edge, saturating at the limit.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (rise || fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TIMEOUT_CYCLES) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign timeout_hit = (idle_cnt_q == TIMEOUT_CYCLES);
`else
  assign timeout_hit = 1'b0;
`endif

  // Shift-register update and frame acceptance on the post-shift control value.
  always_comb begin
    data_sr_d = data_sr_q;
    ctrl_sr_d = ctrl_sr_q;
    ctrl_post = shift_in(ctrl_sr_q, s_data_sync);
    accept    = 1'b0;
    if (rise) begin
      data_sr_d = shift_in(data_sr_q, s_data_sync);
    end else if (fall) begin
      if (ctrl_post == CTRL_WORD) begin
        accept    = 1'b1;
        // Clearing the control register prevents the same frame matching twice.
        ctrl_sr_d = '0;
      end else begin
        ctrl_sr_d = ctrl_post;
      end
    end else if (timeout_hit) begin
      data_sr_d = '0;
      ctrl_sr_d = '0;
    end
  end

  // Output staging: data loads on acceptance, strobe/active/count follow a cycle later.
  always_comb begin
    accept_d   = accept;
    data_d     = accept ? data_sr_q : data_q;
    strobe_d   = accept_q;
    active_d   = active_q | accept_q;
    word_cnt_d = accept_q ? (word_cnt_q + 16'd1) : word_cnt_q;
  end

  // State registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      s_clk_prev_q <= 1'b0;
      data_sr_q    <= '0;
      ctrl_sr_q    <= '0;
      accept_q     <= 1'b0;
      data_q       <= '0;
      strobe_q     <= 1'b0;
      active_q     <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      s_clk_prev_q <= s_clk_prev_d;
      data_sr_q    <= data_sr_d;
      ctrl_sr_q    <= ctrl_sr_d;
      accept_q     <= accept_d;
      data_q       <= data_d;
      strobe_q     <= strobe_d;
      active_q     <= active_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign data     = data_q;
  assign strobe   = strobe_q;
  assign active   = active_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_bitbang_cfg_rx.sv
// Directed bench for bitbang_cfg_rx.
module tb_bitbang_cfg_rx;

  logic        CLK    = 1'b0;
  logic        resetn = 1'b0;
  logic        s_clk  = 1'b0;
  logic        s_data = 1'b0;
  logic [31:0] data;
  logic        strobe;
  logic        active;
  logic [15:0] word_cnt;

  int vectors     = 0;
  int miscompares = 0;

  int          strobe_cnt  = 0;
  int          wide_strobe = 0;
  logic        prev_strobe = 1'b0;
  logic [31:0] strobe_data[$];

  always #5 CLK = ~CLK;

  bitbang_cfg_rx #(
    .CTRL_WORD      (32'h0000_FAB1),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK      (CLK),
    .resetn   (resetn),
    .s_clk    (s_clk),
    .s_data   (s_data),
    .data     (data),
    .strobe   (strobe),
    .active   (active),
    .word_cnt (word_cnt)
  );

  // Strobe monitor, sampled on the falling CLK edge.
  always @(negedge CLK) begin
    if (strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_data.push_back(data);
      if (prev_strobe === 1'b1) wide_strobe = wide_strobe + 1;
    end
    prev_strobe = strobe;
  end

  task automatic do_reset();
    @(negedge CLK);
    resetn = 1'b0;
    s_clk  = 1'b0;
    s_data = 1'b0;
    repeat (3) @(negedge CLK);
    resetn = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // One bit = 5 CLK: data bit, s_clk rise, ctrl bit, s_clk fall, idle.
  task automatic send_bit(input logic d, input logic c);
    @(negedge CLK) s_data = d;
    @(negedge CLK) s_clk  = 1'b1;
    @(negedge CLK) s_data = c;
    @(negedge CLK) s_clk  = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_bits(input logic [31:0] d, input logic [31:0] c,
                           input int from, input int to);
    for (int i = from; i < to; i++) send_bit(d[31-i], c[31-i]);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic [31:0] c);
    send_bits(d, c, 0, 32);
  endtask

  task automatic settle();
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    resetn = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++; if (data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected %h", data, 32'h0); end
    vectors++; if (strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b expected 0", strobe); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b expected 0", active); end
    vectors++; if (word_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_word_cnt: got %h expected 0000", word_cnt); end
    resetn = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_bad_ctrl();
    int base;
    do_reset();
    base = strobe_cnt;
    send_frame(32'h1234_5678, 32'h0000_FAB0);
    settle();
    vectors++; if (strobe_cnt - base !== 0) begin miscompares++; $display("FAIL bad_ctrl_strobes: got %0d expected 0", strobe_cnt - base); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("FAIL bad_ctrl_data: got %h expected %h", data, 32'h0); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL bad_ctrl_active: got %b expected 0", active); end
    vectors++; if (word_cnt !== 16'h0) begin miscompares++; $display("FAIL bad_ctrl_word_cnt: got %h expected 0000", word_cnt); end
  endtask

  task automatic test_single_frame();
    int base;
    do_reset();
    base = strobe_cnt;
    send_frame(32'hDEAD_BEEF, 32'h0000_FAB1);
    settle();
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL single_strobes: got %0d expected 1", strobe_cnt - base); end
    vectors++; if (strobe_data[base] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_strobe_data: got %h expected %h", strobe_data[base], 32'hDEAD_BEEF); end
    vectors++; if (data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_data: got %h expected %h", data, 32'hDEAD_BEEF); end
    vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL single_active: got %b expected 1", active); end
    vectors++; if (word_cnt !== 16'd1) begin miscompares++; $display("FAIL single_word_cnt: got %h expected 0001", word_cnt); end
    vectors++; if (wide_strobe !== 0) begin miscompares++; $display("FAIL single_strobe_width: got %0d wide pulses expected 0", wide_strobe); end
    // A rejected frame afterwards must leave the published word untouched.
    send_frame(32'h1234_5678, 32'h0000_FAB0);
    settle();
    vectors++; if (data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL hold_data: got %h expected %h", data, 32'hDEAD_BEEF); end
    vectors++; if (word_cnt !== 16'd1) begin miscompares++; $display("FAIL hold_word_cnt: got %h expected 0001", word_cnt); end
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL hold_strobes: got %0d expected 1", strobe_cnt - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = strobe_cnt;
    send_frame(32'h0000_0001, 32'h0000_FAB1);
    send_frame(32'hFFFF_FFFF, 32'h0000_FAB1);
    settle();
    vectors++; if (strobe_cnt - base !== 2) begin miscompares++; $display("FAIL b2b_strobes: got %0d expected 2", strobe_cnt - base); end
    vectors++; if (strobe_data[base] !== 32'h0000_0001) begin miscompares++; $display("FAIL b2b_first: got %h expected %h", strobe_data[base], 32'h0000_0001); end
    vectors++; if (strobe_data[base+1] !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL b2b_second: got %h expected %h", strobe_data[base+1], 32'hFFFF_FFFF); end
    vectors++; if (word_cnt !== 16'd2) begin miscompares++; $display("FAIL b2b_word_cnt: got %h expected 0002", word_cnt); end
    vectors++; if (wide_strobe !== 0) begin miscompares++; $display("FAIL b2b_strobe_width: got %0d wide pulses expected 0", wide_strobe); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    do_reset();
    base = strobe_cnt;
    send_bits(32'hCAFE_F00D, 32'h0000_FAB1, 0, 16);
    do_reset();
    send_frame(32'hA5A5_A5A5, 32'h0000_FAB1);
    settle();
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL midrst_strobes: got %0d expected 1", strobe_cnt - base); end
    vectors++; if (strobe_data[base] !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL midrst_data: got %h expected %h", strobe_data[base], 32'hA5A5_A5A5); end
    vectors++; if (word_cnt !== 16'd1) begin miscompares++; $display("FAIL midrst_word_cnt: got %h expected 0001", word_cnt); end
  endtask

  task automatic test_wrap();
    int base;
    do_reset();
    send_frame(32'h1111_2222, 32'h0000_FAB1);
    settle();
    @(negedge CLK);
    force dut.word_cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.word_cnt_q;
    base = strobe_cnt;
    send_frame(32'h3333_4444, 32'h0000_FAB1);
    settle();
    vectors++; if (word_cnt !== 16'h0000) begin miscompares++; $display("FAIL wrap_word_cnt: got %h expected 0000", word_cnt); end
    vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL wrap_active: got %b expected 1", active); end
    vectors++; if (data !== 32'h3333_4444) begin miscompares++; $display("FAIL wrap_data: got %h expected %h", data, 32'h3333_4444); end
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL wrap_strobes: got %0d expected 1", strobe_cnt - base); end
  endtask

`ifdef BITBANG_TIMEOUT_EN
  task automatic test_timeout();
    int base;
    do_reset();
    base = strobe_cnt;
    send_bits(32'h3C3C_3C3C, 32'h0000_FAB1, 0, 20);
    repeat (150) @(negedge CLK);
    send_bits(32'h3C3C_3C3C, 32'h0000_FAB1, 20, 32);
    settle();
    vectors++; if (strobe_cnt - base !== 0) begin miscompares++; $display("FAIL timeout_strobes: got %0d expected 0", strobe_cnt - base); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("FAIL timeout_data: got %h expected %h", data, 32'h0); end
    send_frame(32'h0F0F_1234, 32'h0000_FAB1);
    settle();
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL timeout_recover_strobes: got %0d expected 1", strobe_cnt - base); end
    vectors++; if (data !== 32'h0F0F_1234) begin miscompares++; $display("FAIL timeout_recover_data: got %h expected %h", data, 32'h0F0F_1234); end
  endtask
`endif

  initial begin
    test_reset();
    test_bad_ctrl();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
`ifdef BITBANG_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
